// File: rtl/sram_fifo_addr_path_pkg.sv
// rtl/sram_fifo_addr_path_pkg.sv - shared defaults, strobe idle levels and cycle-FSM state encodings
package sram_fifo_addr_path_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  // Idle levels of the write/read cycle FSM strobes
  localparam logic COUNT_IDLE = 1'b1;
  localparam logic NWE_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    CYC_IDLE  = 3'd0,
    CYC_STEP1 = 3'd1,
    CYC_STEP2 = 3'd2,
    CYC_STEP3 = 3'd3,
    CYC_STEP4 = 3'd4
  } cyc_state_e;

endpackage

// File: rtl/sram_fifo_addr_path_strobe_rise_detect.sv
// rtl/sram_fifo_addr_path_strobe_rise_detect.sv - 0->1 edge detector on a cycle-FSM strobe
module strobe_rise_detect
  import sram_fifo_addr_path_pkg::*;
#(
  parameter logic IDLE = COUNT_IDLE
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic rise_o
);

  logic strobe_q;

  // Reset to the idle level so releasing reset never fakes a rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= IDLE;
    end else begin
      strobe_q <= strobe_i;
    end
  end

  assign rise_o = ~strobe_q & strobe_i;

endmodule

// File: rtl/sram_fifo_addr_path.sv
// rtl/sram_fifo_addr_path.sv - SRAM address/data path turning external SRAM into a circular FIFO
module sram_fifo_addr_path
  import sram_fifo_addr_path_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          latch,
  input  logic          count,
  input  logic          DE,
  input  logic          nWE,
  input  logic          writing,
  input  logic          rd_count,
  input  logic          reading,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic          sram_nWE,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   occupancy,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [DW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_done, rd_done;
  logic          wr_acc, rd_acc;

  strobe_rise_detect #(.IDLE(COUNT_IDLE)) u_wr_rise (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (count),
    .rise_o   (wr_done)
  );

  strobe_rise_detect #(.IDLE(COUNT_IDLE)) u_rd_rise (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (rd_count),
    .rise_o   (rd_done)
  );

  assign full  = (occ_q == DEPTH);
  assign empty = (occ_q == '0);

  // Gating on the current flags makes a full FIFO favour the read and an empty one the write
  assign wr_acc = wr_done & ~full;
  assign rd_acc = rd_done & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    data_d   = data_q;
    ovf_d    = ovf_q | (wr_done & full);
    unf_d    = unf_q | (rd_done & empty);

    if (latch) begin
      data_d = data_in;
    end
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // The read pointer is also the parked address whenever neither FSM owns the bus
  always_comb begin
    if (writing) begin
      addr = wr_ptr_q;
    end else if (reading) begin
      addr = rd_ptr_q;
    end else begin
      addr = rd_ptr_q;
    end
  end

  assign data_out  = data_q;
  assign data_oe   = writing & DE;
  assign sram_nWE  = nWE;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sram_fifo_addr_path.sv
// tb/tb_sram_fifo_addr_path.sv - directed self-checking bench for sram_fifo_addr_path
module tb_sram_fifo_addr_path;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, latch, count, DE, nWE, writing, rd_count, reading;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_oe, sram_nWE, full, empty, overflow, underflow;
  logic [AW:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] wa;

  always #5 clk = ~clk;

  sram_fifo_addr_path #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .latch     (latch),
    .count     (count),
    .DE        (DE),
    .nWE       (nWE),
    .writing   (writing),
    .rd_count  (rd_count),
    .reading   (reading),
    .data_in   (data_in),
    .addr      (addr),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .sram_nWE  (sram_nWE),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [DW-1:0] d, output logic [AW-1:0] a);
    latch = 1'b1; data_in = d;
    tick();
    latch = 1'b0; writing = 1'b1; DE = 1'b1; count = 1'b0;
    tick();
    nWE = 1'b0;
    tick();
    nWE = 1'b1; DE = 1'b0;
    tick();
    count = 1'b1;
    tick();
    a = addr;
    writing = 1'b0;
    tick();
  endtask

  task automatic do_read();
    reading = 1'b1; rd_count = 1'b0;
    tick();
    tick();
    rd_count = 1'b1;
    tick();
    reading = 1'b0;
    tick();
  endtask

  task automatic do_simul();
    writing = 1'b1; count = 1'b0; rd_count = 1'b0;
    tick();
    tick();
    count = 1'b1; rd_count = 1'b1;
    tick();
    writing = 1'b0;
    tick();
  endtask

  task automatic check_ptrs(input string tag, input logic [AW-1:0] wp, input logic [AW-1:0] rp);
    writing = 1'b1;
    #1;
    check({tag, "_wr_ptr"}, addr, wp);
    writing = 1'b0; reading = 1'b1;
    #1;
    check({tag, "_rd_ptr"}, addr, rp);
    reading = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; latch = 1'b0; count = 1'b1; DE = 1'b0; nWE = 1'b1;
    writing = 1'b0; rd_count = 1'b1; reading = 1'b0; data_in = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    repeat (10) tick();
    check("idle_addr", addr, 0);
    check("idle_occ", occupancy, 0);
    check("idle_empty", empty, 1);
    check("idle_full", full, 0);
    check("idle_ovf", overflow, 0);
    check("idle_unf", underflow, 0);
    check("idle_data", data_out, 0);
    check("idle_oe", data_oe, 0);
    check("idle_nwe", sram_nWE, 1);

    // 2: single write, latency of data capture and address advance
    latch = 1'b1; data_in = 8'hA5;
    tick();
    latch = 1'b0; data_in = 8'h00;
    check("latch_data", data_out, 8'hA5);
    writing = 1'b1; DE = 1'b1; count = 1'b0;
    tick();
    nWE = 1'b0;
    #1;
    check("wr_nwe_low", sram_nWE, 0);
    check("wr_oe", data_oe, 1);
    check("wr_addr_during", addr, 0);
    tick();
    nWE = 1'b1; DE = 1'b0;
    tick();
    count = 1'b1;
    #1;
    check("wr_addr_edge1", addr, 0);
    tick();
    check("wr_addr_edge2", addr, 1);
    check("wr_occ1", occupancy, 1);
    check("wr_empty0", empty, 0);
    writing = 1'b0;
    tick();

    // 3: fill to full then overflow
    do_reset();
    for (int i = 0; i < 4; i++) do_write(DW'(8'h10 + i), wa);
    check("fill_full", full, 1);
    check("fill_occ4", occupancy, 4);
    check("fill_ovf0", overflow, 0);
    do_write(8'h55, wa);
    check("ovf_wr_ptr_stays", wa, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_occ4", occupancy, 4);
    check("ovf_data", data_out, 8'h55);

    // 4: drain with rd_ptr wrap then underflow
    for (int i = 1; i <= 4; i++) begin
      do_read();
      check($sformatf("drain_addr%0d", i), addr, i % 4);
      check($sformatf("drain_occ%0d", i), occupancy, 4 - i);
    end
    check("drain_empty", empty, 1);
    check("drain_unf0", underflow, 0);
    do_read();
    check("unf_flag", underflow, 1);
    check("unf_occ0", occupancy, 0);
    check("unf_addr", addr, 0);
    check("unf_ovf_sticky", overflow, 1);

    // 5: simultaneous completion at occupancy 2
    do_reset();
    do_write(8'h01, wa);
    do_write(8'h02, wa);
    do_simul();
    check("sim2_occ", occupancy, 2);
    check_ptrs("sim2", 3, 1);
    check("sim2_flags", {overflow, underflow}, 0);

    // simultaneous when full: read wins
    do_reset();
    for (int i = 0; i < 4; i++) do_write(DW'(i), wa);
    do_simul();
    check("simfull_occ", occupancy, 3);
    check("simfull_ovf", overflow, 1);
    check_ptrs("simfull", 0, 1);

    // simultaneous when empty: write wins
    do_reset();
    do_simul();
    check("simempty_occ", occupancy, 1);
    check("simempty_unf", underflow, 1);
    check("simempty_ovf", overflow, 0);
    check_ptrs("simempty", 1, 0);

    // 6: reset in mid-write, released with count high
    do_reset();
    do_write(8'h77, wa);
    check("pre6_occ", occupancy, 1);
    writing = 1'b1; DE = 1'b1; count = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    count = 1'b1; DE = 1'b0;
    tick();
    writing = 1'b0; reset = 1'b0;
    tick();
    tick();
    check("rst6_occ", occupancy, 0);
    check("rst6_empty", empty, 1);
    check("rst6_data", data_out, 0);
    check("rst6_flags", {overflow, underflow, full}, 0);
    check_ptrs("rst6", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
